// File: rtl/rx_bit_timer_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : rx_bit_timer_ctrl_if
// Description : Handshake bundle between the start-bit detector, the bit
//               timer controller and the receive shift register / control.
// Revision    : 1.0  initial release
// ============================================================================
interface rx_bit_timer_ctrl_if #(
  parameter int CNT_SIZE = 4
);
  logic                start_detect;
  logic                abort;
  logic                shift_strobe;
  logic [CNT_SIZE-1:0] bit_index;
  logic                busy;
  logic                packet_done;

  // Upstream / downstream side: raises start and abort, observes timing
  modport master (
    output start_detect,
    output abort,
    input  shift_strobe,
    input  bit_index,
    input  busy,
    input  packet_done
  );

  // Timer controller side
  modport slave (
    input  start_detect,
    input  abort,
    output shift_strobe,
    output bit_index,
    output busy,
    output packet_done
  );
endinterface
`default_nettype wire

// File: rtl/rx_bit_timer_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : flex_counter / rx_bit_timer_ctrl
// Description : Receive bit timer. A clock-per-bit counter produces one shift
//               strobe per bit period; a bit counter tracks strobes issued and
//               ends the packet after BITS_PER_PKT strobes.
// Revision    : 1.0  initial release
// ============================================================================

// Counts 1..rollover_val and wraps back to 1; rollover_flag is registered and
// is high while count_out equals rollover_val. clear has priority.
module flex_counter #(
  parameter int NUM_CNT_BITS = 4
) (
  input  wire logic                    clk,
  input  wire logic                    n_rst,
  input  wire logic                    clear,
  input  wire logic                    count_enable,
  input  wire logic [NUM_CNT_BITS-1:0] rollover_val,
  output logic      [NUM_CNT_BITS-1:0] count_out,
  output logic                         rollover_flag
);
  logic [NUM_CNT_BITS-1:0] next_count;

  // Next count: clear wins, otherwise increment with wrap to 1
  always_comb begin
    next_count = count_out;
    if (clear) begin
      next_count = '0;
    end else if (count_enable) begin
      if (count_out == rollover_val) begin
        next_count = NUM_CNT_BITS'(1);
      end else begin
        next_count = count_out + 1'b1;
      end
    end
  end

  // Count and flag registers; the flag looks ahead so it aligns with the count
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count_out     <= '0;
      rollover_flag <= 1'b0;
    end else begin
      count_out     <= next_count;
      rollover_flag <= !clear && (next_count == rollover_val);
    end
  end
endmodule

module rx_bit_timer_ctrl #(
  parameter int CNT_SIZE     = 4,
  parameter int CLK_PER_BIT  = 10,
  parameter int BITS_PER_PKT = 9
) (
  input wire logic          clk,
  input wire logic          n_rst,
  rx_bit_timer_ctrl_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state;
  logic                busy_q;
  logic                done_q;
  logic                clear_cnt;
  logic                clk_roll;
  logic                strobe;
  logic                last_strobe;
  logic [CNT_SIZE-1:0] clk_count_unused;
  logic                bit_roll_unused;
  logic [CNT_SIZE-1:0] bit_count;

  // Strobe comes only from registered state, so no input reaches an output
  assign strobe      = clk_roll && (state == RUN);
  assign last_strobe = strobe && (bit_count == CNT_SIZE'(BITS_PER_PKT - 1));

  // Counters run only in RUN and are wiped on the edge that leaves RUN
  assign clear_cnt = (state != RUN) || bus.abort || last_strobe;

  flex_counter #(.NUM_CNT_BITS(CNT_SIZE)) u_clk_cnt (
    .clk          (clk),
    .n_rst        (n_rst),
    .clear        (clear_cnt),
    .count_enable (state == RUN),
    .rollover_val (CNT_SIZE'(CLK_PER_BIT)),
    .count_out    (clk_count_unused),
    .rollover_flag(clk_roll)
  );

  flex_counter #(.NUM_CNT_BITS(CNT_SIZE)) u_bit_cnt (
    .clk          (clk),
    .n_rst        (n_rst),
    .clear        (clear_cnt),
    .count_enable (strobe),
    .rollover_val (CNT_SIZE'(BITS_PER_PKT)),
    .count_out    (bit_count),
    .rollover_flag(bit_roll_unused)
  );

  // Packet sequencer with registered Moore outputs; abort overrides everything
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state  <= IDLE;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.start_detect && !bus.abort) begin
            state  <= RUN;
            busy_q <= 1'b1;
          end else begin
            busy_q <= 1'b0;
          end
        end
        RUN: begin
          if (bus.abort) begin
            state  <= IDLE;
            busy_q <= 1'b0;
            done_q <= 1'b0;
          end else if (last_strobe) begin
            state  <= DONE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end else begin
            busy_q <= 1'b1;
            done_q <= 1'b0;
          end
        end
        DONE: begin
          state  <= IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.shift_strobe = strobe;
  assign bus.bit_index    = bit_count;
  assign bus.busy         = busy_q;
  assign bus.packet_done  = done_q;
endmodule
`default_nettype wire

// File: tb/tb_rx_bit_timer_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_rx_bit_timer_ctrl
// Description : Scoreboard bench for rx_bit_timer_ctrl: default instance and
//               a CLK_PER_BIT=4 / BITS_PER_PKT=3 instance share the stimulus.
// Revision    : 1.0  initial release
// ============================================================================
module tb_rx_bit_timer_ctrl;
  localparam int C0 = 10;
  localparam int B0 = 9;
  localparam int C1 = 4;
  localparam int B1 = 3;

  logic clk = 1'b0;
  logic n_rst = 1'b0;
  logic start_detect = 1'b0;
  logic abort = 1'b0;

  always #5 clk = ~clk;

  rx_bit_timer_ctrl_if #(.CNT_SIZE(4)) bus0 ();
  rx_bit_timer_ctrl_if #(.CNT_SIZE(4)) bus1 ();

  assign bus0.start_detect = start_detect;
  assign bus0.abort        = abort;
  assign bus1.start_detect = start_detect;
  assign bus1.abort        = abort;

  rx_bit_timer_ctrl #(.CNT_SIZE(4), .CLK_PER_BIT(C0), .BITS_PER_PKT(B0)) dut0 (
    .clk  (clk),
    .n_rst(n_rst),
    .bus  (bus0.slave)
  );

  rx_bit_timer_ctrl #(.CNT_SIZE(4), .CLK_PER_BIT(C1), .BITS_PER_PKT(B1)) dut1 (
    .clk  (clk),
    .n_rst(n_rst),
    .bus  (bus1.slave)
  );

  typedef struct packed {
    logic       strobe;
    logic [3:0] idx;
    logic       busy;
    logic       done;
  } obs_t;

  obs_t q0[$];
  obs_t q1[$];
  int   mode0 = 0, t0 = 0;   // mode: 0 idle, 1 in packet (t cycles since accept), 2 done
  int   mode1 = 0, t1 = 0;
  int   checks = 0;
  int   passes = 0;

  // Expected outputs from position within the packet timeline
  function automatic obs_t ref_out(input int c, input int b, input int mode, input int t);
    obs_t o;
    o = '0;
    if (mode == 1) begin
      o.busy = 1'b1;
      if (t > 0) begin
        o.strobe = ((t % c) == 0);
        o.idx    = 4'((t - 1) / c);
      end
    end else if (mode == 2) begin
      o.done = 1'b1;
    end
    return o;
  endfunction

  // Advance the packet timeline by one clock edge
  task automatic ref_step(input int c, input int b, input logic s, input logic a,
                          inout int mode, inout int t);
    case (mode)
      0: if (s && !a) begin mode = 1; t = 0; end
      1: if (a) mode = 0;
         else begin
           t = t + 1;
           if (t == c * b + 1) mode = 2;
         end
      default: mode = 0;
    endcase
  endtask

  task automatic check_obs(input string name, input obs_t act, input obs_t exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s t=%0t: got strobe=%b idx=%0d busy=%b done=%b, expected strobe=%b idx=%0d busy=%b done=%b",
                  name, $time, act.strobe, act.idx, act.busy, act.done,
                  exp.strobe, exp.idx, exp.busy, exp.done);
  endtask

  function automatic obs_t obs0();
    return {bus0.shift_strobe, bus0.bit_index, bus0.busy, bus0.packet_done};
  endfunction

  function automatic obs_t obs1();
    return {bus1.shift_strobe, bus1.bit_index, bus1.busy, bus1.packet_done};
  endfunction

  // Reference model: push the expected post-edge response for each instance
  always @(posedge clk) begin
    if (n_rst) begin
      ref_step(C0, B0, start_detect, abort, mode0, t0);
      ref_step(C1, B1, start_detect, abort, mode1, t1);
      q0.push_back(ref_out(C0, B0, mode0, t0));
      q1.push_back(ref_out(C1, B1, mode1, t1));
    end
  end

  // Reset returns both timelines to idle and drops pending expectations
  always @(negedge n_rst) begin
    mode0 = 0; t0 = 0;
    mode1 = 0; t1 = 0;
    q0.delete();
    q1.delete();
  end

  // Monitor: compare the presented outputs against the queued expectations
  always @(posedge clk) begin
    #1;
    if (q0.size() > 0) check_obs("dut0_cycle", obs0(), q0.pop_front());
    if (q1.size() > 0) check_obs("dut1_cycle", obs1(), q1.pop_front());
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start();
    start_detect = 1'b1;
    @(negedge clk);
    start_detect = 1'b0;
  endtask

  // Assert reset 3ns after an edge and confirm outputs drop without a clock
  task automatic mid_cycle_reset(input string name);
    @(posedge clk);
    #3;
    n_rst = 1'b0;
    #1;
    check_obs({name, "_dut0"}, obs0(), '0);
    check_obs({name, "_dut1"}, obs1(), '0);
    @(negedge clk);
    n_rst = 1'b1;
  endtask

  initial begin
    // Power-up reset, then idle with inputs low
    cycles(2);
    check_obs("por_dut0", obs0(), '0);
    check_obs("por_dut1", obs1(), '0);
    n_rst = 1'b1;
    cycles(5);

    // Full packet
    pulse_start();
    cycles(100);

    // Abort sampled at E45
    pulse_start();
    cycles(44);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    cycles(60);

    // Abort coincident with the last strobe at E91
    pulse_start();
    cycles(90);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    cycles(20);

    // Start pulse inside RUN must not retime anything
    pulse_start();
    cycles(29);
    pulse_start();
    cycles(80);

    // Start held high across several packets
    start_detect = 1'b1;
    cycles(250);
    start_detect = 1'b0;
    cycles(20);

    // Asynchronous reset in the middle of a packet, then a clean restart
    pulse_start();
    cycles(49);
    mid_cycle_reset("async_rst");
    cycles(3);
    pulse_start();
    cycles(100);

    // Randomised traffic with occasional aborts and resets
    for (int i = 0; i < 4000; i++) begin
      start_detect = ($urandom_range(0, 11) == 0);
      abort        = ($urandom_range(0, 149) == 0);
      if ($urandom_range(0, 1499) == 0) begin
        start_detect = 1'b0;
        abort        = 1'b0;
        mid_cycle_reset("rand_rst");
      end else begin
        @(negedge clk);
      end
    end
    start_detect = 1'b0;
    abort        = 1'b0;
    cycles(3);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
`default_nettype wire
